// File: rtl/htpa_pkg.sv
// Shared HTPA frame-RAM definitions used by the frame writer and the x/y RAM scanner.
package htpa_pkg;

   localparam int unsigned HTPA_COLS = 80;
   localparam int unsigned HTPA_ROWS = 64;
   localparam int unsigned HTPA_DW   = 16;
   localparam int unsigned HTPA_AW   = 13;

   // Writer sequencing: wait for sof, fill a bank, hand it to the scanner.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      SWAP  = 2'd2
   } wr_state_e;

endpackage

// File: rtl/htpa_pix_addr_cnt.sv
// Column/row/linear pixel counter for one frame.
// 'first' loads the position just after pixel 0 because pixel 0 is written at address 0 directly.
// 'last_c' flags that the current position is the final pixel of the frame.
module htpa_pix_addr_cnt
   import htpa_pkg::*;
#(
   parameter int unsigned COLS = HTPA_COLS,
   parameter int unsigned ROWS = HTPA_ROWS,
   parameter int unsigned AW   = HTPA_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          first,
   input  logic          adv,
   output logic [AW-1:0] lin,
   output logic          last_c
);

   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] lin_q, lin_d;

   assign last_c = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));
   assign lin    = lin_q;

   // Next position: reload after a frame's first pixel, otherwise step in raster order.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      lin_d = lin_q;
      if (first) begin
         col_d = CW'(1);
         row_d = '0;
         lin_d = AW'(1);
      end else if (adv) begin
         if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         lin_d = last_c ? '0 : lin_q + AW'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
         lin_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         lin_q <= lin_d;
      end
   end

endmodule

// File: rtl/htpa_frame_writer.sv
// HTPA frame writer: streams sensor pixels row-major into one bank of a two-bank
// frame RAM and hands each completed bank to the x/y RAM scanner.
// Optional build macro HTPA_FRAME_WRITER_CHECKSUM_EN adds a per-frame pixel sum output.
module htpa_frame_writer
   import htpa_pkg::*;
#(
   parameter int unsigned COLS = HTPA_COLS,
   parameter int unsigned ROWS = HTPA_ROWS,
   parameter int unsigned DW   = HTPA_DW,
   parameter int unsigned AW   = HTPA_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] pix_data,
   input  logic          pix_valid,
   input  logic          pix_sof,
   output logic          pix_ready,
   input  logic          scan_busy,
   output logic          wr_en,
   output logic [AW:0]   wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          rd_bank,
   output logic          scan_start,
   output logic          frame_done,
   output logic          err_short
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
   ,
   output logic [DW-1:0] frame_sum
`endif
);

   wr_state_e     state_q, state_d;
   logic          wbank_q, wbank_d;
   logic          rd_bank_q, rd_bank_d;
   logic          wr_en_q, wr_en_d;
   logic [AW:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          scan_start_q, scan_start_d;
   logic          frame_done_q, frame_done_d;
   logic          err_short_q, err_short_d;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
   logic [DW-1:0] sum_q, sum_d;
   logic [DW-1:0] frame_sum_q, frame_sum_d;
`endif

   logic          accept;
   logic          cnt_first;
   logic          cnt_adv;
   logic [AW-1:0] cnt_lin;
   logic          cnt_last_c;

   htpa_pix_addr_cnt #(
      .COLS (COLS),
      .ROWS (ROWS),
      .AW   (AW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .first  (cnt_first),
      .adv    (cnt_adv),
      .lin    (cnt_lin),
      .last_c (cnt_last_c)
   );

   assign pix_ready  = (state_q != SWAP);
   assign accept     = pix_valid & pix_ready;

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign rd_bank    = rd_bank_q;
   assign scan_start = scan_start_q;
   assign frame_done = frame_done_q;
   assign err_short  = err_short_q;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
   assign frame_sum  = frame_sum_q;
`endif

   // Next-state, RAM write and handshake pulse generation.
   always_comb begin
      state_d      = state_q;
      wbank_d      = wbank_q;
      rd_bank_d    = rd_bank_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      scan_start_d = 1'b0;
      frame_done_d = 1'b0;
      err_short_d  = 1'b0;
      cnt_first    = 1'b0;
      cnt_adv      = 1'b0;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
      sum_d        = sum_q;
      frame_sum_d  = frame_sum_q;
`endif
      unique case (state_q)
         IDLE: begin
            // Pixels before a sof belong to no frame and are dropped.
            if (accept && pix_sof) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {wbank_q, AW'(0)};
               wr_data_d = pix_data;
               cnt_first = 1'b1;
               state_d   = WRITE;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
               sum_d     = pix_data;
`endif
            end
         end
         WRITE: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_data_d = pix_data;
               if (pix_sof) begin
                  // Early sof: abandon the partial frame and restart in the same bank.
                  err_short_d = 1'b1;
                  wr_addr_d   = {wbank_q, AW'(0)};
                  cnt_first   = 1'b1;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
                  sum_d       = pix_data;
`endif
               end else begin
                  wr_addr_d = {wbank_q, cnt_lin};
                  cnt_adv   = 1'b1;
                  if (cnt_last_c) begin
                     state_d = SWAP;
                  end
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
                  sum_d     = sum_q + pix_data;
`endif
               end
            end
         end
         SWAP: begin
            // Hand over only once the scanner has finished the previous bank.
            if (!scan_busy) begin
               rd_bank_d    = wbank_q;
               wbank_d      = ~wbank_q;
               scan_start_d = 1'b1;
               frame_done_d = 1'b1;
               state_d      = IDLE;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
               frame_sum_d  = sum_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wbank_q      <= 1'b0;
         rd_bank_q    <= 1'b1;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         scan_start_q <= 1'b0;
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
         sum_q        <= '0;
         frame_sum_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wbank_q      <= wbank_d;
         rd_bank_q    <= rd_bank_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         scan_start_q <= scan_start_d;
         frame_done_q <= frame_done_d;
         err_short_q  <= err_short_d;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
         sum_q        <= sum_d;
         frame_sum_q  <= frame_sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_htpa_frame_writer.sv
// Directed bench for htpa_frame_writer; the checksum test is active when
// HTPA_FRAME_WRITER_CHECKSUM_EN is defined for both bench and design.
module tb_htpa_frame_writer;
   import htpa_pkg::*;

   localparam int unsigned DW   = HTPA_DW;
   localparam int unsigned AW   = HTPA_AW;
   localparam int          NPIX = HTPA_COLS * HTPA_ROWS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] pix_data = '0;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic          pix_ready;
   logic          scan_busy = 1'b0;
   logic          wr_en;
   logic [AW:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_bank;
   logic          scan_start;
   logic          frame_done;
   logic          err_short;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
   logic [DW-1:0] frame_sum;
`endif

   int checks = 0;
   int passed = 0;

   htpa_frame_writer dut (
      .clk        (clk),
      .rst        (rst),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .pix_ready  (pix_ready),
      .scan_busy  (scan_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_bank    (rd_bank),
      .scan_start (scan_start),
      .frame_done (frame_done),
      .err_short  (err_short)
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
      ,
      .frame_sum  (frame_sum)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; scan_busy = 1'b0; pix_data = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Streams pixels start_idx..start_idx+n-1 (sof on index 0, data = index) and
   // counts any write that is not exactly {bank, index} one cycle later.
   task automatic stream(input int n, input int start_idx, input logic bank, output int bad);
      bad = 0;
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = start_idx + k;
         if (pix_ready !== 1'b1) bad++;
         pix_valid = 1'b1;
         pix_sof   = (idx == 0);
         pix_data  = DW'(idx);
         step();
         if (wr_en !== 1'b1 || wr_addr !== {bank, AW'(idx)} || wr_data !== DW'(idx) ||
             frame_done !== 1'b0 || err_short !== 1'b0) begin
            if (bad < 3)
               $display("  idx %0d: wr_en=%b wr_addr=%h wr_data=%h done=%b err=%b",
                        idx, wr_en, wr_addr, wr_data, frame_done, err_short);
            bad++;
         end
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({wr_en, wr_addr, wr_data, scan_start, frame_done, err_short} !== '0)
         $display("FAIL reset_outputs: got wr_en=%b wr_addr=%h wr_data=%h start=%b done=%b err=%b, expected all 0",
                  wr_en, wr_addr, wr_data, scan_start, frame_done, err_short);
      else passed++;
      checks++;
      if (rd_bank !== 1'b1) $display("FAIL reset_rd_bank: got %b expected 1", rd_bank);
      else passed++;
      checks++;
      if (pix_ready !== 1'b1) $display("FAIL reset_pix_ready: got %b expected 1", pix_ready);
      else passed++;
   endtask

   task automatic test_full_frame();
      int bad;
      stream(NPIX, 0, 1'b0, bad);
      checks++;
      if (bad !== 0) $display("FAIL full_writes: got %0d bad writes, expected 0", bad);
      else passed++;
      checks++;
      if (pix_ready !== 1'b0) $display("FAIL full_swap_ready: got %b expected 0", pix_ready);
      else passed++;
      step();
      checks++;
      if ({frame_done, scan_start, rd_bank, wr_en} !== 4'b1100)
         $display("FAIL full_swap: got done,start,rd_bank,wr_en=%b expected 1100",
                  {frame_done, scan_start, rd_bank, wr_en});
      else passed++;
      step();
      checks++;
      if ({frame_done, scan_start, rd_bank, pix_ready} !== 4'b0001)
         $display("FAIL full_pulse_end: got done,start,rd_bank,ready=%b expected 0001",
                  {frame_done, scan_start, rd_bank, pix_ready});
      else passed++;
   endtask

   // Follows the full frame: writes go to bank 1 until reset returns everything to bank 0.
   task automatic test_rst_mid_frame();
      int bad;
      stream(1000, 0, 1'b1, bad);
      checks++;
      if (bad !== 0) $display("FAIL rst_pre_writes: got %0d bad writes, expected 0", bad);
      else passed++;
      rst = 1'b1;
      pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 16'h0BAD;
      step();
      pix_valid = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data, scan_start, frame_done, err_short} !== '0)
         $display("FAIL rst_mid_outputs: got wr_en=%b wr_addr=%h wr_data=%h start=%b done=%b err=%b, expected all 0",
                  wr_en, wr_addr, wr_data, scan_start, frame_done, err_short);
      else passed++;
      checks++;
      if (rd_bank !== 1'b1) $display("FAIL rst_mid_rd_bank: got %b expected 1", rd_bank);
      else passed++;
      rst = 1'b0;
      stream(3, 0, 1'b0, bad);
      checks++;
      if (bad !== 0) $display("FAIL rst_post_writes: got %0d bad writes, expected 0 (bank 0 from addr 0)", bad);
      else passed++;
   endtask

   task automatic test_idle_drop();
      int bad;
      do_reset();
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         pix_valid = 1'b1; pix_sof = 1'b0; pix_data = DW'(16'h0100 + k);
         step();
         if (wr_en !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL idle_drop: got %0d writes, expected 0", bad);
      else passed++;
      pix_sof = 1'b1; pix_data = 16'h1234;
      step();
      pix_valid = 1'b0; pix_sof = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 14'h0000, 16'h1234})
         $display("FAIL idle_first_sof: got wr_en=%b addr=%h data=%h expected 1 0000 1234",
                  wr_en, wr_addr, wr_data);
      else passed++;
   endtask

   task automatic test_short_frame();
      int bad;
      do_reset();
      stream(300, 0, 1'b0, bad);
      checks++;
      if (bad !== 0) $display("FAIL short_pre_writes: got %0d bad writes, expected 0", bad);
      else passed++;
      pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 16'h5555;
      step();
      pix_valid = 1'b0; pix_sof = 1'b0;
      checks++;
      if ({err_short, wr_en, wr_addr, wr_data} !== {1'b1, 1'b1, 14'h0000, 16'h5555})
         $display("FAIL short_restart: got err=%b wr_en=%b addr=%h data=%h expected 1 1 0000 5555",
                  err_short, wr_en, wr_addr, wr_data);
      else passed++;
      stream(NPIX - 1, 1, 1'b0, bad);
      checks++;
      if (bad !== 0) $display("FAIL short_refill: got %0d bad writes, expected 0", bad);
      else passed++;
      step();
      checks++;
      if ({frame_done, scan_start, rd_bank, err_short} !== 4'b1100)
         $display("FAIL short_done: got done,start,rd_bank,err=%b expected 1100",
                  {frame_done, scan_start, rd_bank, err_short});
      else passed++;
   endtask

   task automatic test_busy_hold();
      int bad;
      do_reset();
      scan_busy = 1'b1;
      stream(NPIX, 0, 1'b0, bad);
      checks++;
      if (bad !== 0) $display("FAIL busy_writes: got %0d bad writes, expected 0", bad);
      else passed++;
      pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 16'hABCD;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (pix_ready !== 1'b0) bad++;
         step();
         if (wr_en !== 1'b0 || frame_done !== 1'b0 || scan_start !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL busy_wait: got %0d bad cycles, expected 0", bad);
      else passed++;
      scan_busy = 1'b0;
      step();
      checks++;
      if ({frame_done, scan_start, rd_bank, wr_en, pix_ready} !== 5'b11001)
         $display("FAIL busy_swap: got done,start,rd_bank,wr_en,ready=%b expected 11001",
                  {frame_done, scan_start, rd_bank, wr_en, pix_ready});
      else passed++;
      step();
      pix_valid = 1'b0; pix_sof = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 14'h2000, 16'hABCD})
         $display("FAIL busy_held_sof: got wr_en=%b addr=%h data=%h expected 1 2000 abcd",
                  wr_en, wr_addr, wr_data);
      else passed++;
   endtask

   task automatic test_random_gaps();
      int bad;
      int n;
      logic [15:0] sum;
      logic        acc;
      do_reset();
      bad = 0; n = 0; sum = '0;
      for (int cyc = 0; cyc < 20000 && n < NPIX; cyc++) begin
         acc = (n == 0) || ($urandom_range(0, 3) != 0);
         pix_valid = acc;
         pix_sof   = acc && (n == 0);
         pix_data  = DW'($urandom);
         step();
         if (acc) begin
            sum = sum + pix_data;
            if (wr_en !== 1'b1 || wr_addr !== {1'b0, AW'(n)} || wr_data !== pix_data) bad++;
            n++;
         end else if (wr_en !== 1'b0) begin
            bad++;
         end
      end
      pix_valid = 1'b0; pix_sof = 1'b0;
      checks++;
      if (n !== NPIX) $display("FAIL gaps_timeout: got %0d pixels accepted, expected %0d", n, NPIX);
      else passed++;
      checks++;
      if (bad !== 0) $display("FAIL gaps_writes: got %0d bad cycles, expected 0", bad);
      else passed++;
      step();
      checks++;
      if (frame_done !== 1'b1) $display("FAIL gaps_done: got %b expected 1", frame_done);
      else passed++;
`ifdef HTPA_FRAME_WRITER_CHECKSUM_EN
      checks++;
      if (frame_sum !== sum) $display("FAIL gaps_checksum: got %h expected %h", frame_sum, sum);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_rst_mid_frame();
      test_idle_drop();
      test_short_frame();
      test_busy_hold();
      test_random_gaps();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/htpa_frame_writer.md
Name: htpa_frame_writer

Overview:
- Producer end of the HTPA frame RAM.
- Accepts the sensor pixel stream and writes it row-major into one bank of a two-bank frame RAM.
- On frame completion, hands the filled bank to the RAM scanner, pulses the scanner's START, and refills the other bank.
- Sits between the sensor readout and the existing x/y RAM scanner.

Parameters:
- COLS, 80, active pixels per row.
- ROWS, 64, rows per frame.
- DW, 16, pixel data width.
- AW, 13, per-bank address width (must satisfy 2^AW >= COLS*ROWS).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- pix_data  in  DW  sensor pixel value
- pix_valid  in  1  pixel_data valid
- pix_sof  in  1  first-pixel-of-frame marker, qualified by pix_valid
- pix_ready  out  1  writer accepts pixel this cycle
- scan_busy  in  1  scanner active (scanner's set output)
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW+1  {bank, linear address}
- wr_data  out  DW  RAM write data
- rd_bank  out  1  bank the scanner reads
- scan_start  out  1  one-cycle START pulse to scanner
- frame_done  out  1  one-cycle pulse, frame committed
- err_short  out  1  one-cycle pulse, frame aborted by early pix_sof

Behaviour:
- Reset (rst=1 at an edge), all outputs registered:
  - wr_en=0, wr_addr=0, wr_data=0, rd_bank=1, scan_start=0, frame_done=0, err_short=0.
  - Write bank = 0; state IDLE; col=0, row=0.
  - rst mid-frame discards the partial frame; no pulses are issued.
- Accept condition: pix_valid & pix_ready.
- pix_ready: 1 in IDLE and WRITE, 0 in SWAP (combinational from state).
- IDLE:
  - Accepted pixel with pix_sof=0: dropped, no write.
  - Accepted pixel with pix_sof=1: written at linear address 0; col=1; go to WRITE.
- WRITE:
  - Each accepted pixel is written at the linear counter value.
  - col increments; at col=COLS-1, col wraps to 0 and row increments.
  - Linear address is kept as an incrementing counter, not multiplied out.
  - Accepting pixel (COLS-1, ROWS-1) goes to SWAP.
  - An accepted pixel with pix_sof=1 before the frame completes:
    - err_short pulses next cycle.
    - That pixel is written at address 0 of the same bank; col=1, row=0.
    - Stays in WRITE; no bank swap.
- Write latency: wr_en/wr_addr/wr_data register exactly one cycle after acceptance. wr_en is 0 on cycles without acceptance.
- SWAP:
  - Waits while scan_busy=1.
  - First cycle with scan_busy=0:
    - rd_bank <= current write bank; write bank toggles.
    - scan_start=1 and frame_done=1 for exactly one cycle.
    - Next state IDLE.
  - pix_sof arriving during SWAP is back-pressured (pix_ready=0), never lost.
- Banks: write bank is always ~rd_bank after the first swap; the writer never writes the bank being scanned.
- Back-to-back frames: the next sof may be accepted the cycle after the swap, in IDLE.

Optional Feature:
- Macro: HTPA_FRAME_WRITER_CHECKSUM_EN.
- Enabled:
  - Adds output frame_sum[DW-1:0].
  - A modulo-2^DW sum of all pixels of the current frame is accumulated on acceptance; restarts on every accepted sof.
  - The sum is registered into frame_sum on the frame_done cycle.
  - frame_sum resets to 0; it is unchanged by err_short.
- Disabled: port and accumulator absent; all other behaviour identical.

Decomposition:
- Shared package htpa_pkg:
  - HTPA_COLS=80, HTPA_ROWS=64, HTPA_DW=16, HTPA_AW=13.
  - Writer state enum {IDLE, WRITE, SWAP}.
  - Scanner and writer both import it.
- One natural sub-module, htpa_pix_addr_cnt: col/row/linear counter with clear-to-first-pixel and last-pixel flag.

Test Plan:
- Full frame, continuous pix_valid, sof on first pixel, pixel value = index:
  - 5120 writes to bank 0, addresses 0..5119.
  - wr_data matches, one-cycle latency.
  - frame_done and scan_start pulse once; rd_bank 1→0.
- Frame completes with scan_busy held 1 for 20 cycles:
  - pix_ready=0 for those cycles, no writes.
  - Swap occurs the cycle after scan_busy falls.
  - A second frame's sof held during the wait is written to bank 1, address 0.
- sof reasserted at pixel 300:
  - err_short pulses once.
  - Next write is bank 0, address 0.
  - No frame_done until 5120 further pixels.
- Pixels without sof in IDLE (10 pixels):
  - wr_en stays 0.
  - First sof pixel is written to address 0.
- rst asserted at pixel 1000:
  - All outputs return to reset values.
  - rd_bank=1.
  - Next frame is written to bank 0 from address 0.
- Random pix_valid gaps, checksum enabled: frame_sum equals the modulo-65536 sum computed by the scoreboard.
